sb_tx_pkt_serializer: RTL and testbench

- Parametrised sideband TX back-end: buffers framed packets in a FIFO and serialises each one LSB-first onto the sideband data lane.
- Produces a gated-clock enable for the TXCKSB driver and enforces a minimum idle gap between packets.
- Adds flush, overflow detection, almost-full back-pressure and a transmit-enable hold.
- Sits between the packet encoder/framing stage and the sideband pad drivers, in a single clock domain.

---
 rtl/sb_tx_pkt_serializer.sv | 179 +++++++++++++++++
 tb/tb_sb_tx_pkt_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_pkt_serializer.sv
// Purpose: sideband TX back-end; queues framed packets in a FIFO and shifts each one out LSB-first with a TXCKSB clock enable.
// Latency: push accepted at edge N, head loaded at edge N+1, first bit on the lane in the cycle after N+1; each packet is PKT_W bits, then GAP_UI idle cycles, then 1 IDLE cycle.
// Backpressure: o_full/o_almost_full warn the producer; a push while full is dropped and latches o_overflow; i_tx_en low holds the queue after the in-flight packet.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_en/i_wr_data packet push; i_tx_en start permit; i_flush sync abort;
//        o_full/o_empty/o_almost_full/o_count/o_overflow FIFO status; o_ser_data/o_clk_en serial lane; o_pkt_done last-bit pulse; o_busy serializer active.
module sb_tx_pkt_serializer #(
    parameter int PKT_W     = 64,
    parameter int DEPTH     = 4,
    parameter int GAP_UI    = 32,
    parameter int AF_THRESH = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [PKT_W-1:0]           i_wr_data,
    input  logic                       i_tx_en,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_ser_data,
    output logic                       o_clk_en,
    output logic                       o_pkt_done,
    output logic                       o_busy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(PKT_W);
    // Keep the gap counter at least one bit wide so GAP_UI of 0 or 1 still elaborates.
    localparam int GW = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_W-1);
    localparam logic [BW-1:0] BIT_PENUL = BW'(PKT_W-2);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_UI > 0) ? GAP_UI-1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ovf_q, ovf_d;
    logic [1:0]       state_q, state_d;
    logic [PKT_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             ser_q, ser_d, clk_en_q, clk_en_d, done_q, done_d;
    logic             push, pop;

    // Push and pop are both judged on registered flags; flush overrides both.
    assign push = i_wr_en && !full_q && !i_flush;
    assign pop  = (state_q == ST_IDLE) && !empty_q && i_tx_en && !i_flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (i_wr_en && full_q);
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THRESH));
    end

    // The lane outputs are computed one cycle ahead so they leave straight from flops.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ser_d     = 1'b0;
        clk_en_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    ser_d     = mem_q[rptr_q][0];
                    shreg_d   = mem_q[rptr_q] >> 1;
                    clk_en_d  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_UI == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    ser_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    clk_en_d  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Raise done together with the last bit it marks.
                    done_d    = (bit_cnt_q == BIT_PENUL);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_flush) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            ser_d     = 1'b0;
            clk_en_d  = 1'b0;
            done_d    = 1'b0;
        end
    end

    // Packet storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wptr_q] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_q     <= 1'b0;
            clk_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_q     <= ser_d;
            clk_en_q  <= clk_en_d;
            done_q    <= done_d;
        end
    end

    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_almost_full = af_q;
    assign o_count       = count_q;
    assign o_overflow    = ovf_q;
    assign o_ser_data    = ser_q;
    assign o_clk_en      = clk_en_q;
    assign o_pkt_done    = done_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_pkt_serializer.sv
// Purpose: self-checking bench for sb_tx_pkt_serializer (default build plus a GAP_UI=0, PKT_W=8 build).
// Latency: expected packets queued at push time, compared when the DUT pulses o_pkt_done.
// Backpressure: bench drives tx_en/flush/reset to exercise hold, abort and overflow paths.
module tb_sb_tx_pkt_serializer;

    localparam int PKT_W = 64;
    localparam int GAP   = 32;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, tx_en, flush;
    logic [63:0] wr_data;
    logic        full, empty, af, ovf, ser, clk_en, done, busy;
    logic [2:0]  count;

    logic        wr_en0, tx_en0, flush0;
    logic [7:0]  wr_data0;
    logic        full0, empty0, af0, ovf0, ser0, clk_en0, done0, busy0;
    logic [2:0]  count0;

    always #5 clk = ~clk;

    sb_tx_pkt_serializer #(.PKT_W(64), .DEPTH(4), .GAP_UI(32), .AF_THRESH(3)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_tx_en(tx_en), .i_flush(flush), .o_full(full), .o_empty(empty),
        .o_almost_full(af), .o_count(count), .o_overflow(ovf), .o_ser_data(ser),
        .o_clk_en(clk_en), .o_pkt_done(done), .o_busy(busy)
    );

    sb_tx_pkt_serializer #(.PKT_W(8), .DEPTH(4), .GAP_UI(0), .AF_THRESH(3)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en0), .i_wr_data(wr_data0),
        .i_tx_en(tx_en0), .i_flush(flush0), .o_full(full0), .o_empty(empty0),
        .o_almost_full(af0), .o_count(count0), .o_overflow(ovf0), .o_ser_data(ser0),
        .o_clk_en(clk_en0), .o_pkt_done(done0), .o_busy(busy0)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    int          cyc = 0;
    int          nbits = 0;
    logic [63:0] acc = '0;
    bit          tight = 1'b0;
    bit          have_last = 1'b0;
    int          last_done = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Serial-lane monitor: rebuilds each packet and scores it on o_pkt_done.
    always @(negedge clk) begin
        cyc++;
        if (clk_en) begin
            if (nbits == 0 && tight && have_last)
                check("pkt_period_gap", 64'(cyc - last_done), 64'(GAP + 2));
            if (nbits < 64) acc[nbits] = ser;
            nbits++;
        end
        if (done) begin
            check("done_on_last_bit", {63'd0, clk_en}, 64'd1);
            check("pkt_len", 64'(nbits), 64'(PKT_W));
            if (exp_q.size() == 0) check("unexpected_pkt", 64'd1, 64'd0);
            else check("pkt_data", acc, exp_q.pop_front());
            nbits     = 0;
            acc       = '0;
            have_last = 1'b1;
            last_done = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          g;
        int          bad_en;
        int          bad_cnt;
        bit          en0[40];
        bit          dn0[40];
        logic [15:0] bits0;
        int          nb0;
        int          nd0;
        int          d1;

        rst_n = 1'b0; wr_en = 1'b0; tx_en = 1'b0; flush = 1'b0; wr_data = '0;
        wr_en0 = 1'b0; tx_en0 = 1'b0; flush0 = 1'b0; wr_data0 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_af", {63'd0, af}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_ser", {63'd0, ser}, 64'd0);
        check("rst_clk_en", {63'd0, clk_en}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Single packet: latency, bit order, gap length.
        tx_en = 1'b1;
        exp_q.push_back(64'h0000_0000_0000_A5C3);
        push(64'h0000_0000_0000_A5C3);
        check("t1_count_after_push", {61'd0, count}, 64'd1);
        check("t1_empty_after_push", {63'd0, empty}, 64'd0);
        check("t1_clk_en_before_load", {63'd0, clk_en}, 64'd0);
        @(posedge clk); #1;
        check("t1_first_clk_en", {63'd0, clk_en}, 64'd1);
        check("t1_first_bit", {63'd0, ser}, 64'd1);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_count_after_pop", {61'd0, count}, 64'd0);
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        check("t1_done_seen", {63'd0, done}, 64'd1);
        g = 0;
        repeat (GAP) begin
            @(negedge clk);
            if (!clk_en && busy && !ser) g++;
        end
        check("t1_gap_cycles", 64'(g), 64'(GAP));
        @(negedge clk);
        check("t1_busy_after_gap", {63'd0, busy}, 64'd0);

        // Fill with tx_en low, overflow, then drain in order with tight spacing.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back(d);
            push(d);
            check("t2_count", {61'd0, count}, 64'(i + 1));
            check("t2_af", {63'd0, af}, {63'd0, (i + 1 >= 3)});
            check("t2_full", {63'd0, full}, {63'd0, (i + 1 == 4)});
        end
        check("t2_ovf_before", {63'd0, ovf}, 64'd0);
        push({$urandom, $urandom});
        check("t2_ovf_set", {63'd0, ovf}, 64'd1);
        check("t2_count_held", {61'd0, count}, 64'd4);
        have_last = 1'b0;
        tight     = 1'b1;
        tx_en     = 1'b1;
        for (int k = 0; k < 600 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
        check("t2_drained", 64'(exp_q.size()), 64'd0);
        tight = 1'b0;
        check("t2_ovf_sticky", {63'd0, ovf}, 64'd1);

        // Flush mid-packet with a simultaneous push.
        d = {$urandom, $urandom};
        exp_q.push_back(d);
        push(d);
        for (int k = 0; k < 10 && !clk_en; k++) @(negedge clk);
        check("t3_started", {63'd0, clk_en}, 64'd1);
        repeat (20) @(negedge clk);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = {$urandom, $urandom};
        @(posedge clk); #1;
        flush = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        nbits = 0;
        acc   = '0;
        check("t3_clk_en", {63'd0, clk_en}, 64'd0);
        check("t3_count", {61'd0, count}, 64'd0);
        check("t3_empty", {63'd0, empty}, 64'd1);
        check("t3_ovf_cleared", {63'd0, ovf}, 64'd0);
        check("t3_busy", {63'd0, busy}, 64'd0);
        check("t3_done", {63'd0, done}, 64'd0);
        g = 0;
        repeat (150) begin
            @(negedge clk);
            if (clk_en || done) g++;
        end
        check("t3_no_tx_after_flush", 64'(g), 64'd0);

        // tx_en dropped mid-packet holds the second packet.
        tx_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back(d);
            push(d);
        end
        tx_en = 1'b1;
        for (int k = 0; k < 10 && !clk_en; k++) @(negedge clk);
        check("t4_started", {63'd0, clk_en}, 64'd1);
        repeat (5) @(negedge clk);
        tx_en = 1'b0;
        check("t4_count_in_flight", {61'd0, count}, 64'd1);
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        check("t4_done_seen", {63'd0, done}, 64'd1);
        bad_en  = 0;
        bad_cnt = 0;
        repeat (GAP + 40) begin
            @(negedge clk);
            if (clk_en) bad_en++;
            if (count != 3'd1) bad_cnt++;
        end
        check("t4_no_start", 64'(bad_en), 64'd0);
        check("t4_count_hold", 64'(bad_cnt), 64'd0);
        check("t4_idle", {63'd0, busy}, 64'd0);
        check("t4_queued", 64'(exp_q.size()), 64'd1);
        tx_en = 1'b1;
        for (int k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // GAP_UI=0 build: exactly one IDLE cycle between packets.
        wr_en0 = 1'b1; wr_data0 = 8'h5A;
        @(posedge clk); #1;
        wr_data0 = 8'hC3;
        @(posedge clk); #1;
        wr_en0 = 1'b0;
        tx_en0 = 1'b1;
        nb0 = 0; nd0 = 0; bits0 = '0; d1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            en0[i] = clk_en0;
            dn0[i] = done0;
            if (done0) nd0++;
            if (done0 && d1 < 0) d1 = i;
            if (clk_en0) begin
                if (nb0 < 16) bits0[nb0] = ser0;
                nb0++;
            end
        end
        check("t5_bits", {48'd0, bits0}, 64'h0000_0000_0000_C35A);
        check("t5_nbits", 64'(nb0), 64'd16);
        check("t5_ndone", 64'(nd0), 64'd2);
        if (d1 < 0 || d1 + 2 >= 40) begin
            check("t5_first_done_found", 64'd0, 64'd1);
        end else begin
            check("t5_idle_cycle", {63'd0, en0[d1 + 1]}, 64'd0);
            check("t5_next_first_bit", {63'd0, en0[d1 + 2]}, 64'd1);
        end

        // Asynchronous reset mid-shift.
        d = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_q.push_back(d);
        push(d);
        for (int k = 0; k < 10 && !clk_en; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("t6_pre_ser", {63'd0, ser}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_ser", {63'd0, ser}, 64'd0);
        check("t6_clk_en", {63'd0, clk_en}, 64'd0);
        check("t6_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        nbits = 0;
        acc   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_empty", {63'd0, empty}, 64'd1);
        check("t6_count", {61'd0, count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
